des_iterative_core: RTL and testbench

- Iterative single-block DES engine built around the existing combinational `fFunction` (32-bit data in, 48-bit subkey in, 32-bit out).
- Applies IP and PC-1 on load, then runs one Feistel round per clock for 16 rounds with an on-the-fly key schedule, then applies FP.
- Supports encrypt and decrypt, with a start/busy/done handshake.
- Sits between the block-mode wrapper (ECB/CBC, next planned block) and the round datapath.

---
 rtl/des_iterative_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_des_iterative_core.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/des_iterative_core.sv
// Iterative DES block engine: one Feistel round per clock, key schedule computed
// on the fly, encrypt/decrypt selected per block, start/busy/done handshake.
module des_iterative_core #(
    parameter bit KEY_PARITY_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] din,
    input  logic [63:0] key,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Permutation tables list the source DES bit number (1 = MSB) for each output bit.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25
    };
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };
    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1
    };
    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25
    };

    // S-boxes S1..S8, each 64 nibbles indexed by {row, column}.
    localparam logic [0:7][0:63][3:0] SBOX = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    // Round function: expand, mix subkey, substitute, permute.
    function automatic logic [31:0] f_function(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s_out;
        logic [5:0]  chunk;
        x = perm_e(r) ^ k;
        for (int s = 0; s < 8; s++) begin
            chunk = x[47-6*s -: 6];
            s_out[31-4*s -: 4] = SBOX[s][{chunk[5], chunk[0], chunk[4:1]}];
        end
        return perm_p(s_out);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Every key byte must carry odd parity.
    function automatic logic key_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) ok = ok & (^k[8*b +: 8]);
        return ok;
    endfunction

    state_t      state_q, state_d;
    logic [4:0]  rnd_q, rnd_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        dec_q, dec_d;
    logic        perr_q, perr_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [63:0] dout_q, dout_d;

    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic        shift_one_enc, shift_one_dec;

    // Key schedule: rotate C/D for the current round and derive its subkey.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        c_rot = c_q;
        d_rot = d_q;
        // Single-position rotations fall on rounds 1, 2, 9, 16 (encrypt) and,
        // mirrored through S[18-rnd], on rounds 2, 9, 16 for decrypt.
        shift_one_enc = (rnd_q == 5'd1) || (rnd_q == 5'd2) || (rnd_q == 5'd9) || (rnd_q == 5'd16);
        shift_one_dec = (rnd_q == 5'd2) || (rnd_q == 5'd9) || (rnd_q == 5'd16);
        if (!dec_q) begin
            c_rot = rotl28(c_q, !shift_one_enc);
            d_rot = rotl28(d_q, !shift_one_enc);
        end else if (rnd_q != 5'd1) begin
            // Decrypt round 1 uses K16 = PC-2(C0,D0) directly.
            c_rot = rotr28(c_q, !shift_one_dec);
            d_rot = rotr28(d_q, !shift_one_dec);
        end
        subkey = perm_pc2({c_rot, d_rot});
    end

    // Control FSM and round datapath next-state logic.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        l_d     = l_q;
        r_d     = r_q;
        c_d     = c_q;
        d_d     = d_q;
        dec_d   = dec_q;
        perr_d  = perr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dec_d = decrypt;
                    if (KEY_PARITY_CHECK && !key_parity_ok(key)) begin
                        // Rejected key: skip the rounds and report straight away.
                        perr_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        perr_d     = 1'b0;
                        {l_d, r_d} = perm_ip(din);
                        {c_d, d_d} = perm_pc1(key);
                        rnd_d      = 5'd1;
                        state_d    = ROUND;
                    end
                end
            end
            ROUND: begin
                l_d = r_q;
                r_d = l_q ^ f_function(r_q, subkey);
                c_d = c_rot;
                d_d = d_rot;
                if (rnd_q == 5'd16) begin
                    rnd_d   = 5'd0;
                    state_d = FINISH;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            FINISH: begin
                done_d = 1'b1;
                if (perr_q) begin
                    err_d = 1'b1;
                end else begin
                    err_d  = 1'b0;
                    // Undo the last round's swap before the final permutation.
                    dout_d = perm_fp({r_q, l_q});
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            dec_q   <= 1'b0;
            perr_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            dec_q   <= dec_d;
            perr_q  <= perr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign err  = err_q;
    assign dout = dout_q;

endmodule

// File: tb/tb_des_iterative_core.sv
// Directed bench for des_iterative_core: known-answer vectors, handshake timing,
// held start, mid-operation reset, key parity rejection and round trips.
module tb_des_iterative_core;

    localparam logic [63:0] K1     = 64'h133457799BBCDFF1;
    localparam logic [63:0] K1_BAD = 64'h133457799BBCDFF0;
    localparam logic [63:0] PT1    = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1    = 64'h85E813540F0AB405;
    localparam logic [63:0] K2     = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2    = 64'h8787878787878787;
    localparam logic [63:0] CT2    = 64'h0000000000000000;
    localparam logic [63:0] K3     = 64'h0101010101010101;
    localparam logic [63:0] PT3    = 64'h8000000000000000;
    localparam logic [63:0] CT3    = 64'h95F8A5E5DD31D900;
    localparam logic [63:0] ONES   = 64'hFFFFFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n, start, start_p, decrypt;
    logic [63:0] din, key;
    logic        busy, done, err;
    logic [63:0] dout;
    logic        busy_p, done_p, err_p;
    logic [63:0] dout_p;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    des_iterative_core #(.KEY_PARITY_CHECK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .din(din), .key(key),
        .busy(busy), .done(done), .err(err), .dout(dout)
    );

    des_iterative_core #(.KEY_PARITY_CHECK(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n), .start(start_p), .decrypt(decrypt), .din(din), .key(key),
        .busy(busy_p), .done(done_p), .err(err_p), .dout(dout_p)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one block and wait (bounded) for its done pulse; lat counts edges after the start edge.
    task automatic run_block(input bit use_p, input logic dec, input logic [63:0] d, input logic [63:0] k,
                             output logic [63:0] res, output logic res_err, output int lat,
                             output bit busy_ok);
        decrypt = dec;
        din     = d;
        key     = k;
        if (use_p) start_p = 1'b1;
        else       start   = 1'b1;
        tick();
        start   = 1'b0;
        start_p = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (((use_p ? done_p : done) !== 1'b1) && lat < 40) begin
            if ((use_p ? busy_p : busy) !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        res     = use_p ? dout_p : dout;
        res_err = use_p ? err_p : err;
    endtask

    // Full successful block: latency, busy window, result and error flag.
    task automatic expect_block(input string tag, input bit use_p, input logic dec,
                                input logic [63:0] d, input logic [63:0] k, input logic [63:0] exp);
        logic [63:0] res;
        logic        res_err;
        int          lat;
        bit          busy_ok;
        run_block(use_p, dec, d, k, res, res_err, lat, busy_ok);
        check({tag, "_latency"}, lat, 17);
        check({tag, "_busy_window"}, busy_ok, 1);
        check({tag, "_idle_at_done"}, use_p ? busy_p : busy, 0);
        check({tag, "_dout"}, res, exp);
        check({tag, "_err"}, res_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] res, second, rnd_pt, rnd_key, rnd_ct;
        logic        res_err;
        int          lat, pulses;
        bit          busy_ok;

        rst_n = 1'b0; start = 1'b0; start_p = 1'b0; decrypt = 1'b0; din = '0; key = '0;
        tick();
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err",  err,  0);
        check("reset_dout", dout, 0);
        rst_n = 1'b1;
        tick();

        // Known-answer encrypt, then the done pulse must last exactly one cycle.
        expect_block("enc_kat1", 1'b0, 1'b0, PT1, K1, CT1);
        tick();
        check("done_one_cycle", done, 0);
        check("dout_held", dout, CT1);

        expect_block("dec_kat1", 1'b0, 1'b1, CT1, K1, PT1);
        expect_block("enc_kat2", 1'b0, 1'b0, PT2, K2, CT2);
        expect_block("dec_kat2", 1'b0, 1'b1, CT2, K2, PT2);
        expect_block("enc_kat3", 1'b0, 1'b0, PT3, K3, CT3);
        expect_block("dec_kat3", 1'b0, 1'b1, CT3, K3, PT3);

        // start held high; din changes mid-block and must not affect the first result.
        decrypt = 1'b0; din = PT1; key = K1; start = 1'b1;
        tick();
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (lat == 5) din = ONES;
            tick();
            lat++;
        end
        check("held_latency", lat, 17);
        check("held_dout", dout, CT1);
        // start is still high in the done cycle, so the next block is accepted here.
        tick();
        lat = 1;
        start = 1'b0;
        check("held_accept_busy", busy, 1);
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("held_second_gap", lat, 18);
        second = dout;
        expect_block("held_second_roundtrip", 1'b0, 1'b1, second, K1, ONES);

        // Reset at round 8 abandons the block: cleared outputs and no done afterwards.
        decrypt = 1'b0; din = PT2; key = K2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_dout", dout, 0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        expect_block("midrst_fresh_enc", 1'b0, 1'b0, PT1, K1, CT1);

        // Parity-checking instance: a bad key is rejected quickly with dout left alone.
        run_block(1'b1, 1'b0, PT1, K1_BAD, res, res_err, lat, busy_ok);
        check("parity_bad_latency_le2", (lat >= 1 && lat <= 2), 1);
        check("parity_bad_err", res_err, 1);
        check("parity_bad_dout", res, 0);
        expect_block("parity_good", 1'b1, 1'b0, PT1, K1, CT1);
        run_block(1'b1, 1'b0, PT2, K1_BAD, res, res_err, lat, busy_ok);
        check("parity_bad2_err", res_err, 1);
        check("parity_bad2_dout_held", res, CT1);
        tick();
        check("parity_err_held", err_p, 1);

        // Random round trips: decrypting the ciphertext must give back the plaintext.
        for (int n = 0; n < 6; n++) begin
            rnd_pt  = {$urandom, $urandom};
            rnd_key = {$urandom, $urandom};
            run_block(1'b0, 1'b0, rnd_pt, rnd_key, rnd_ct, res_err, lat, busy_ok);
            check("rand_enc_latency", lat, 17);
            run_block(1'b0, 1'b1, rnd_ct, rnd_key, res, res_err, lat, busy_ok);
            check("rand_roundtrip", res, rnd_pt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
